// File: rtl/ctrl_mux.sv
// rtl/ctrl_mux.sv - frame-level round-robin stream merger with source-index sideband
module ctrl_mux #(
  parameter int DATA_WIDTH     = 16,
  parameter int S_COUNT        = 2,
  parameter int SELECTOR_WIDTH = $clog2(S_COUNT),
  parameter int KEEP_ENABLE    = 1,
  parameter int KEEP_WIDTH     = DATA_WIDTH/8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_val_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0] s_val_axis_tkeep,
  input  logic [S_COUNT-1:0]            s_val_axis_tlast,
  input  logic [S_COUNT-1:0]            s_val_axis_tvalid,
  output logic [S_COUNT-1:0]            s_val_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_val_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_val_axis_tkeep,
  output logic                          m_val_axis_tlast,
  output logic                          m_val_axis_tvalid,
  input  logic                          m_val_axis_tready,
  output logic [SELECTOR_WIDTH-1:0]     m_source_tdata,
  output logic                          m_source_tvalid,
  input  logic                          m_source_tready
);

  typedef enum logic {IDLE, PASS} state_t;

  state_t                    state, state_next;
  logic [SELECTOR_WIDTH-1:0] grant, last_grant, winner, cand;
  logic                      found, slot_free, out_ready, take_grant, accept;
  logic [DATA_WIDTH-1:0]     in_data [S_COUNT];
  logic [KEEP_WIDTH-1:0]     in_keep [S_COUNT];
  logic [KEEP_WIDTH-1:0]     sel_keep;
  logic                      sel_last;

  for (genvar i = 0; i < S_COUNT; i++) begin : g_unpack
    assign in_data[i] = s_val_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign in_keep[i] = s_val_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
  end

  // Without keep support every beat is a whole frame.
  assign sel_keep  = (KEEP_ENABLE != 0) ? in_keep[grant] : '1;
  assign sel_last  = (KEEP_ENABLE != 0) ? s_val_axis_tlast[grant] : 1'b1;
  assign out_ready = !m_val_axis_tvalid || m_val_axis_tready;
  assign slot_free = !m_source_tvalid || m_source_tready;

  // Rotating search starting just past the previous winner.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = last_grant;
    for (int k = 0; k < S_COUNT; k++) begin
      cand = (cand == SELECTOR_WIDTH'(S_COUNT-1)) ? '0 : cand + SELECTOR_WIDTH'(1);
      if (!found && s_val_axis_tvalid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_next        = state;
    s_val_axis_tready = '0;
    take_grant        = 1'b0;
    accept            = 1'b0;
    case (state)
      IDLE: begin
        if (found && slot_free) begin
          take_grant = 1'b1;
          state_next = PASS;
        end
      end
      PASS: begin
        s_val_axis_tready[grant] = out_ready;
        accept = out_ready && s_val_axis_tvalid[grant];
        if (accept && sel_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      grant             <= '0;
      last_grant        <= SELECTOR_WIDTH'(S_COUNT-1);
      m_source_tdata    <= '0;
      m_source_tvalid   <= 1'b0;
      m_val_axis_tdata  <= '0;
      m_val_axis_tkeep  <= '0;
      m_val_axis_tlast  <= 1'b0;
      m_val_axis_tvalid <= 1'b0;
    end else begin
      state <= state_next;
      // Tag slot: a grant only happens when the slot is free or draining now.
      if (take_grant) begin
        grant           <= winner;
        last_grant      <= winner;
        m_source_tdata  <= winner;
        m_source_tvalid <= 1'b1;
      end else if (m_source_tready) begin
        m_source_tvalid <= 1'b0;
      end
      if (accept) begin
        m_val_axis_tdata  <= in_data[grant];
        m_val_axis_tkeep  <= sel_keep;
        m_val_axis_tlast  <= sel_last;
        m_val_axis_tvalid <= 1'b1;
      end else if (m_val_axis_tready) begin
        m_val_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ctrl_mux.sv
// tb/tb_ctrl_mux.sv - directed bench for ctrl_mux (4-input keep build and 2-input no-keep build)
module tb_ctrl_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] in_data [4];
  logic [1:0]  in_keep [4];
  logic [3:0]  in_last  = '0;
  logic [3:0]  in_valid = '0;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic [3:0]  s_tready;
  logic [15:0] m_tdata;
  logic [1:0]  m_tkeep;
  logic        m_tlast, m_tvalid;
  logic        m_tready = 1'b1;
  logic [1:0]  src_tdata;
  logic        src_tvalid;
  logic        src_tready = 1'b1;

  assign s_tdata = {in_data[3], in_data[2], in_data[1], in_data[0]};
  assign s_tkeep = {in_keep[3], in_keep[2], in_keep[1], in_keep[0]};

  ctrl_mux #(.DATA_WIDTH(16), .S_COUNT(4), .KEEP_ENABLE(1)) dut (
    .clk(clk), .rst(rst),
    .s_val_axis_tdata(s_tdata), .s_val_axis_tkeep(s_tkeep), .s_val_axis_tlast(in_last),
    .s_val_axis_tvalid(in_valid), .s_val_axis_tready(s_tready),
    .m_val_axis_tdata(m_tdata), .m_val_axis_tkeep(m_tkeep), .m_val_axis_tlast(m_tlast),
    .m_val_axis_tvalid(m_tvalid), .m_val_axis_tready(m_tready),
    .m_source_tdata(src_tdata), .m_source_tvalid(src_tvalid), .m_source_tready(src_tready)
  );

  logic [31:0] n_data  = '0;
  logic [3:0]  n_keep  = '0;
  logic [1:0]  n_last  = '0;
  logic [1:0]  n_valid = '0;
  logic [1:0]  n_ready;
  logic [15:0] nm_data;
  logic [1:0]  nm_keep;
  logic        nm_last, nm_valid;
  logic        nm_ready = 1'b1;
  logic [0:0]  ns_data;
  logic        ns_valid;
  logic        ns_ready = 1'b1;

  ctrl_mux #(.DATA_WIDTH(16), .S_COUNT(2), .KEEP_ENABLE(0)) dut_nk (
    .clk(clk), .rst(rst),
    .s_val_axis_tdata(n_data), .s_val_axis_tkeep(n_keep), .s_val_axis_tlast(n_last),
    .s_val_axis_tvalid(n_valid), .s_val_axis_tready(n_ready),
    .m_val_axis_tdata(nm_data), .m_val_axis_tkeep(nm_keep), .m_val_axis_tlast(nm_last),
    .m_val_axis_tvalid(nm_valid), .m_val_axis_tready(nm_ready),
    .m_source_tdata(ns_data), .m_source_tvalid(ns_valid), .m_source_tready(ns_ready)
  );

  int vectors = 0;
  int miscompares = 0;

  function automatic int flen(input int src, input int fr, input bit fixed3);
    return fixed3 ? 3 : 1 + (src + fr) % 3;
  endfunction

  function automatic logic [15:0] bval(input int src, input int fr, input int b);
    return 16'((src << 12) | ((fr % 256) << 4) | b);
  endfunction

  function automatic logic [1:0] kval(input int src, input int fr, input int b, input bit fixed3);
    if (b == flen(src, fr, fixed3) - 1 && src % 2 == 0) return 2'b01;
    return 2'b11;
  endfunction

  task automatic clear_inputs();
    for (int i = 0; i < 4; i++) begin
      in_data[i] = '0;
      in_keep[i] = '0;
    end
    in_last = '0; in_valid = '0;
    n_data = '0; n_keep = '0; n_last = '0; n_valid = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    m_tready = 1'b1; src_tready = 1'b1; nm_ready = 1'b1; ns_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    in_valid = 4'hF; n_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      in_data[i] = 16'hFFFF; in_keep[i] = 2'b11;
    end
    in_last = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({m_tvalid, m_tdata, m_tkeep, m_tlast, src_tvalid, src_tdata, s_tready} !== 27'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 0",
               {m_tvalid, m_tdata, m_tkeep, m_tlast, src_tvalid, src_tdata, s_tready});
    end
    vectors++;
    if ({nm_valid, nm_data, ns_valid, n_ready} !== 20'd0) begin
      miscompares++;
      $display("FAIL reset_outputs_nk: got %h expected 0", {nm_valid, nm_data, ns_valid, n_ready});
    end
    rst = 1'b0; n_valid = '0;
    @(posedge clk); #1;
    vectors++;
    if ({src_tvalid, src_tdata, s_tready} !== {1'b1, 2'd0, 4'b0001}) begin
      miscompares++;
      $display("FAIL first_grant: got %b expected 1_00_0001", {src_tvalid, src_tdata, s_tready});
    end
    do_reset();
  endtask

  // All sources stay valid until they have sent their share, so grants rotate strictly.
  task automatic run_frames(input int total, input bit rand_ready, input bit fixed3, input int budget);
    int f[4], b[4];
    int per, out_frame, out_beat, tags, last_tag_cyc, cyc, src, fr;
    bit [3:0] fs;
    logic [18:0] exp_beat;
    per = total / 4;
    for (int i = 0; i < 4; i++) begin f[i] = 0; b[i] = 0; end
    out_frame = 0; out_beat = 0; tags = 0; last_tag_cyc = 0;
    m_tready = 1'b1; src_tready = 1'b1;
    for (cyc = 0; cyc < budget && out_frame < total; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (f[i] < per) begin
          in_valid[i] = 1'b1;
          in_data[i]  = bval(i, f[i], b[i]);
          in_keep[i]  = kval(i, f[i], b[i], fixed3);
          in_last[i]  = (b[i] == flen(i, f[i], fixed3) - 1);
        end else begin
          in_valid[i] = 1'b0; in_data[i] = '0; in_keep[i] = '0; in_last[i] = 1'b0;
        end
      end
      if (rand_ready) m_tready = 1'($urandom_range(0, 1));
      @(negedge clk);
      fs = in_valid & s_tready;
      if (src_tvalid && src_tready) begin
        vectors++;
        if (src_tdata !== 2'(tags % 4)) begin
          miscompares++;
          $display("FAIL tag_order tag %0d: got %0d expected %0d", tags, src_tdata, tags % 4);
        end
        if (fixed3 && tags > 0) begin
          vectors++;
          if (cyc - last_tag_cyc != 4) begin
            miscompares++;
            $display("FAIL frame_period tag %0d: got %0d cycles expected 4", tags, cyc - last_tag_cyc);
          end
        end
        last_tag_cyc = cyc;
        tags++;
      end
      if (m_tvalid && m_tready) begin
        src = out_frame % 4; fr = out_frame / 4;
        exp_beat = {bval(src, fr, out_beat), kval(src, fr, out_beat, fixed3),
                    1'(out_beat == flen(src, fr, fixed3) - 1)};
        vectors++;
        if ({m_tdata, m_tkeep, m_tlast} !== exp_beat) begin
          miscompares++;
          $display("FAIL beat frame %0d beat %0d: got %h expected %h",
                   out_frame, out_beat, {m_tdata, m_tkeep, m_tlast}, exp_beat);
        end
        if (out_beat == flen(src, fr, fixed3) - 1) begin
          out_frame++; out_beat = 0;
        end else begin
          out_beat++;
        end
      end
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        if (fs[i]) begin
          if (b[i] == flen(i, f[i], fixed3) - 1) begin f[i]++; b[i] = 0; end
          else b[i]++;
        end
      end
    end
    vectors++;
    if (out_frame != total || tags != total) begin
      miscompares++;
      $display("FAIL frame_count: got %0d frames %0d tags expected %0d", out_frame, tags, total);
    end
    do_reset();
  endtask

  task automatic test_contention();
    run_frames(12, 1'b0, 1'b1, 200);
  endtask

  task automatic test_data_backpressure();
    run_frames(100, 1'b1, 1'b0, 3000);
  endtask

  task automatic test_tag_backpressure();
    int nlast;
    nlast = 0;
    src_tready = 1'b0;
    in_valid = 4'b0011; in_last = 4'b0011;
    in_data[0] = 16'hC000; in_data[1] = 16'hC001;
    in_keep[0] = 2'b11; in_keep[1] = 2'b11;
    repeat (20) begin
      @(negedge clk);
      if (m_tvalid && m_tready && m_tlast) nlast++;
      @(posedge clk); #1;
    end
    vectors++;
    if (nlast != 1) begin
      miscompares++;
      $display("FAIL tag_bp_frames: got %0d expected 1", nlast);
    end
    @(negedge clk);
    vectors++;
    if ({s_tready, src_tvalid, src_tdata} !== {4'b0000, 1'b1, 2'd0}) begin
      miscompares++;
      $display("FAIL tag_bp_stall: got %b expected 0000_1_00", {s_tready, src_tvalid, src_tdata});
    end
    src_tready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({src_tvalid, src_tdata, s_tready} !== {1'b1, 2'd1, 4'b0010}) begin
      miscompares++;
      $display("FAIL tag_bp_release: got %b expected 1_01_0010", {src_tvalid, src_tdata, s_tready});
    end
    do_reset();
  endtask

  task automatic test_keep_disabled();
    int cnt;
    cnt = 0;
    n_valid = 2'b11; n_data = {16'h5A5A, 16'hA5A5}; n_last = 2'b00; n_keep = 4'b0000;
    repeat (16) begin
      @(negedge clk);
      if (nm_valid && nm_ready) begin
        vectors++;
        if ({nm_data, nm_keep, nm_last} !== {((cnt % 2) != 0) ? 16'h5A5A : 16'hA5A5, 2'b11, 1'b1}) begin
          miscompares++;
          $display("FAIL nokeep_beat %0d: got %h_%b_%b", cnt, nm_data, nm_keep, nm_last);
        end
        cnt++;
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (cnt < 6) begin
      miscompares++;
      $display("FAIL nokeep_count: got %0d expected at least 6", cnt);
    end
    do_reset();
  endtask

  task automatic test_reset_mid_frame();
    int b, cyc;
    bit fire;
    b = 0;
    in_valid = 4'b0001; in_keep[0] = 2'b11;
    for (cyc = 0; cyc < 10 && b < 2; cyc++) begin
      in_data[0] = 16'h1000 + 16'(b); in_last[0] = (b == 3);
      @(negedge clk);
      fire = in_valid[0] && s_tready[0];
      @(posedge clk); #1;
      if (fire) b++;
    end
    vectors++;
    if (b != 2) begin
      miscompares++;
      $display("FAIL midreset_progress: got %0d beats expected 2", b);
    end
    in_data[0] = 16'h1002; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if ({m_tvalid, src_tvalid, s_tready} !== 6'd0) begin
      miscompares++;
      $display("FAIL midreset_clear: got %b expected 0", {m_tvalid, src_tvalid, s_tready});
    end
    in_valid = 4'b0011; in_last = 4'b0011;
    in_data[0] = 16'h2000; in_data[1] = 16'h3000; in_keep[1] = 2'b11;
    @(posedge clk); #1;
    vectors++;
    if ({src_tvalid, src_tdata} !== 3'b100) begin
      miscompares++;
      $display("FAIL midreset_regrant: got %b expected 100", {src_tvalid, src_tdata});
    end
    @(posedge clk); #1;
    vectors++;
    if ({m_tvalid, m_tdata, m_tlast} !== {1'b1, 16'h2000, 1'b1}) begin
      miscompares++;
      $display("FAIL midreset_first_beat: got %h expected 1_2000_1", {m_tvalid, m_tdata, m_tlast});
    end
    do_reset();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_contention();
    test_tag_backpressure();
    test_data_backpressure();
    test_keep_disabled();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
